// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall controller for the 5-stage datapath: latch enables/flushes,
// PC write enable, sticky halt, memory-wait freeze and saturating stall/flush counters.
module hazard_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic             idex_dREN,
  input  logic [4:0]       idex_rt,
  input  logic             exmem_dREN,
  input  logic             exmem_dWEN,
  input  logic             branch_taken,
  input  logic             halt_wb,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             exmem_flush,
  output logic             memwb_en,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned REG_W = 5;

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALTED} state_t;

  state_t state, next_state;
  logic   mem_busy;
  logic   load_use;
  logic   flush_inc;
  logic   stall_inc;

  assign mem_busy = (exmem_dREN | exmem_dWEN) & ~dhit;
  // $0 is never a real load destination, so it cannot create a hazard
  assign load_use = idex_dREN & (idex_rt != REG_W'(0)) &
                    ((idex_rt == ifid_rs) | (ifid_uses_rt & (idex_rt == ifid_rt)));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= RUN;
    else       state <= next_state;
  end

  // Priority: halted, memory freeze, branch flush, load-use bubble, fetch miss, run
  always_comb begin
    next_state  = state;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_en     = 1'b0;
    idex_flush  = 1'b0;
    exmem_en    = 1'b0;
    exmem_flush = 1'b0;
    memwb_en    = 1'b0;
    halted      = 1'b0;
    flush_inc   = 1'b0;
    if (!nRST) begin
      next_state = RUN;
    end else if (state == HALTED) begin
      halted = 1'b1;
    end else begin
      if (mem_busy) begin
        next_state = MEM_WAIT;
      end else begin
        next_state = RUN;
        memwb_en   = 1'b1;
        exmem_en   = 1'b1;
        idex_en    = 1'b1;
        if (branch_taken) begin
          pc_en       = 1'b1;
          ifid_en     = 1'b1;
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
          flush_inc   = 1'b1;
        end else if (load_use) begin
          idex_flush = 1'b1;
        end else if (!ihit) begin
          ifid_en    = 1'b1;
          ifid_flush = 1'b1;
        end else begin
          pc_en   = 1'b1;
          ifid_en = 1'b1;
        end
      end
      // The halt retires this cycle regardless of what else is going on
      if (halt_wb) begin
        memwb_en   = 1'b1;
        next_state = HALTED;
      end
    end
  end

  assign stall_inc = (state != HALTED) & ~pc_en;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc && (flush_cnt != {CNT_W{1'b1}})) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; a narrow-counter instance shares the stimulus for saturation.
module tb_hazard_ctrl;

  localparam logic [8:0] RUN_V  = 9'b110101010;
  localparam logic [8:0] LU_V   = 9'b000111010;
  localparam logic [8:0] BR_V   = 9'b111111110;
  localparam logic [8:0] FM_V   = 9'b011101010;
  localparam logic [8:0] ZERO_V = 9'b000000000;
  localparam logic [8:0] HALT_V = 9'b000000001;
  localparam logic [8:0] MWH_V  = 9'b000000010;

  logic       CLK, nRST;
  logic       ihit, dhit, ifid_uses_rt, idex_dREN, exmem_dREN, exmem_dWEN;
  logic       branch_taken, halt_wb;
  logic [4:0] ifid_rs, ifid_rt, idex_rt;

  logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush;
  logic        memwb_en, halted;
  logic [31:0] stall_cnt, flush_cnt;
  logic        pc_en_s, ifid_en_s, ifid_flush_s, idex_en_s, idex_flush_s, exmem_en_s;
  logic        exmem_flush_s, memwb_en_s, halted_s;
  logic [3:0]  stall_cnt_s, flush_cnt_s;

  logic [8:0] fl, fl_s;
  assign fl   = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush,
                 memwb_en, halted};
  assign fl_s = {pc_en_s, ifid_en_s, ifid_flush_s, idex_en_s, idex_flush_s, exmem_en_s,
                 exmem_flush_s, memwb_en_s, halted_s};

  int checks   = 0;
  int failures = 0;

  hazard_ctrl dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ifid_uses_rt(ifid_uses_rt), .idex_dREN(idex_dREN), .idex_rt(idex_rt),
    .exmem_dREN(exmem_dREN), .exmem_dWEN(exmem_dWEN), .branch_taken(branch_taken),
    .halt_wb(halt_wb), .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en),
    .exmem_flush(exmem_flush), .memwb_en(memwb_en), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_ctrl #(.CNT_W(4)) dut_s (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ifid_uses_rt(ifid_uses_rt), .idex_dREN(idex_dREN), .idex_rt(idex_rt),
    .exmem_dREN(exmem_dREN), .exmem_dWEN(exmem_dWEN), .branch_taken(branch_taken),
    .halt_wb(halt_wb), .pc_en(pc_en_s), .ifid_en(ifid_en_s), .ifid_flush(ifid_flush_s),
    .idex_en(idex_en_s), .idex_flush(idex_flush_s), .exmem_en(exmem_en_s),
    .exmem_flush(exmem_flush_s), .memwb_en(memwb_en_s), .halted(halted_s),
    .stall_cnt(stall_cnt_s), .flush_cnt(flush_cnt_s)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_fl(input string tag, input logic [8:0] exp);
    check(tag, 64'(fl), 64'(exp));
    check({tag, "_s"}, 64'(fl_s), 64'(exp));
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    ihit = 1'b1; dhit = 1'b1; ifid_uses_rt = 1'b0; idex_dREN = 1'b0;
    exmem_dREN = 1'b0; exmem_dWEN = 1'b0; branch_taken = 1'b0; halt_wb = 1'b0;
    ifid_rs = 5'd0; ifid_rt = 5'd0; idex_rt = 5'd0;
  endtask

  task automatic rand_in();
    ihit = 1'($urandom); dhit = 1'($urandom); ifid_uses_rt = 1'($urandom);
    idex_dREN = 1'($urandom); exmem_dREN = 1'($urandom); exmem_dWEN = 1'($urandom);
    branch_taken = 1'($urandom); halt_wb = 1'($urandom);
    ifid_rs = 5'($urandom); ifid_rt = 5'($urandom); idex_rt = 5'($urandom);
  endtask

  task automatic apply_reset();
    nRST = 1'b0;
    rand_in();
    #1;
    chk_fl("rst_flags", ZERO_V);
    check("rst_stall", 64'(stall_cnt), 64'd0);
    check("rst_flush", 64'(flush_cnt), 64'd0);
    tick();
    nRST = 1'b1;
    idle();
    #1;
    chk_fl("rst_run", RUN_V);
  endtask

  initial begin
    nRST = 1'b0;
    idle();
    tick();
    apply_reset();

    // load-use on rs: one bubble, then the condition is gone
    idex_dREN = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5;
    #1 chk_fl("lu_rs", LU_V);
    tick();
    check("lu_stall1", 64'(stall_cnt), 64'd1);
    idex_dREN = 1'b0;
    #1 chk_fl("lu_after", RUN_V);
    tick();
    check("lu_stall_hold", 64'(stall_cnt), 64'd1);
    // rt match only counts when rt is a source
    idex_dREN = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd3; ifid_rt = 5'd5; ifid_uses_rt = 1'b0;
    #1 chk_fl("lu_rt_unused", RUN_V);
    ifid_uses_rt = 1'b1;
    #1 chk_fl("lu_rt_used", LU_V);
    tick();
    check("lu_stall2", 64'(stall_cnt), 64'd2);
    idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
    #1 chk_fl("lu_r0", RUN_V);
    tick();
    check("lu_r0_stall", 64'(stall_cnt), 64'd2);

    // branch overrides load-use and fetch miss
    apply_reset();
    idex_dREN = 1'b1; idex_rt = 5'd7; ifid_rs = 5'd7; branch_taken = 1'b1; ihit = 1'b0;
    #1 chk_fl("br_lu", BR_V);
    tick();
    check("br_flush_cnt", 64'(flush_cnt), 64'd1);
    check("br_flush_cnt_s", 64'(flush_cnt_s), 64'd1);
    check("br_stall_cnt", 64'(stall_cnt), 64'd0);
    idle();

    // memory wait: full freeze for 3 cycles
    apply_reset();
    exmem_dREN = 1'b1; dhit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk_fl("memwait", ZERO_V);
      tick();
    end
    check("memwait_stall", 64'(stall_cnt), 64'd3);
    dhit = 1'b1;
    #1 chk_fl("memwait_done", RUN_V);
    tick();
    check("memwait_stall_hold", 64'(stall_cnt), 64'd3);

    // halt from a clean cycle, then inputs are ignored
    apply_reset();
    halt_wb = 1'b1;
    #1 chk_fl("halt_cycle", RUN_V);
    tick();
    for (int i = 0; i < 10; i++) begin
      rand_in();
      #1 chk_fl("halted", HALT_V);
      tick();
    end
    check("halt_stall_frozen", 64'(stall_cnt), 64'd0);
    check("halt_flush_frozen", 64'(flush_cnt), 64'd0);
    apply_reset();
    check("halt_cleared", 64'(halted), 64'd0);

    // halt beats memory wait for the transition but outputs stay frozen
    exmem_dWEN = 1'b1; dhit = 1'b0; halt_wb = 1'b1;
    #1 chk_fl("halt_memwait", MWH_V);
    tick();
    check("halt_memwait_stall", 64'(stall_cnt), 64'd1);
    for (int i = 0; i < 3; i++) begin
      rand_in();
      #1 chk_fl("halted2", HALT_V);
      tick();
    end
    check("halted2_stall", 64'(stall_cnt), 64'd1);

    // fetch miss drives the counters into saturation on the narrow instance
    apply_reset();
    ihit = 1'b0;
    #1 chk_fl("fetch_miss", FM_V);
    for (int i = 0; i < 20; i++) tick();
    check("sat_stall_s", 64'(stall_cnt_s), 64'd15);
    check("sat_stall", 64'(stall_cnt), 64'd20);
    apply_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
